// File: rtl/name_scheduler_if.sv
// -----------------------------------------------------------------------------
// name_scheduler_if
// Groups the requester handshakes, the display-side controls and the
// status outputs of name_scheduler into one bundle.
//   master : the environment side (requesters, display, flush source)
//   slave  : the scheduler itself
// Signals:
//   req_a_valid/req_a_name/req_a_ready : requester A (front-panel logic)
//   req_b_valid/req_b_name/req_b_ready : requester B (host pins)
//   flush      : drop the queue and the current name
//   word_done  : one-cycle pulse, current word finished on the display
//   name       : registered name select to the display
//   busy       : controller is not idle
//   queue_level: registered FIFO occupancy
// -----------------------------------------------------------------------------
interface name_scheduler_if #(
  parameter int unsigned FIFO_DEPTH = 4
) ();
  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic             req_a_valid;
  logic [2:0]       req_a_name;
  logic             req_a_ready;
  logic             req_b_valid;
  logic [2:0]       req_b_name;
  logic             req_b_ready;
  logic             flush;
  logic             word_done;
  logic [2:0]       name;
  logic             busy;
  logic [LVL_W-1:0] queue_level;

  modport master (
    output req_a_valid, req_a_name, req_b_valid, req_b_name, flush, word_done,
    input  req_a_ready, req_b_ready, name, busy, queue_level
  );

  modport slave (
    input  req_a_valid, req_a_name, req_b_valid, req_b_name, flush, word_done,
    output req_a_ready, req_b_ready, name, busy, queue_level
  );
endinterface

// File: rtl/name_scheduler.sv
// -----------------------------------------------------------------------------
// name_scheduler
// Chooses which name the seven-segment display shows. Two requesters submit
// 3-bit name codes; a round-robin arbiter admits at most one per cycle into a
// small circular FIFO. A three-state controller (IDLE/LOAD/SHOW) pops the
// head, holds it for REPEAT complete word passes, then moves on, falling back
// to DEFAULT_NAME when the queue runs dry.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : name_scheduler_if.slave (handshakes, flush, word_done, status)
// Parameters:
//   FIFO_DEPTH   : queue entries, power of two, 2..8
//   REPEAT       : word passes per queued name, 1..15
//   DEFAULT_NAME : name shown while idle
// -----------------------------------------------------------------------------
module name_scheduler #(
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter logic [3:0]  REPEAT       = 4'd2,
  parameter logic [2:0]  DEFAULT_NAME = 3'd0
) (
  input logic              clk,
  input logic              reset,
  name_scheduler_if.slave  bus
);
  localparam int unsigned      PTR_W    = $clog2(FIFO_DEPTH);
  localparam int unsigned      LVL_W    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);
  localparam logic [3:0]       LAST_REP = REPEAT - 4'd1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_SHOW = 2'd2;

  logic [1:0]       r_state;
  logic [2:0]       r_name;
  logic [3:0]       r_rep;
  logic [LVL_W-1:0] r_level;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic             r_last_b;   // 1: B was granted most recently
  logic [2:0]       r_mem [FIFO_DEPTH];

  logic             w_can_push;
  logic             w_grant_a;
  logic             w_grant_b;
  logic             w_push;
  logic             w_pop;
  logic [2:0]       w_push_name;
  logic [LVL_W-1:0] w_level_next;
  logic             w_last_pass;

  // Fullness is judged on the registered level only, so a pop in the same
  // cycle never opens a slot for a push.
  assign w_can_push = !reset && !bus.flush && (r_level < FULL_LVL);

  // Round robin: on a tie the requester that was not granted last wins.
  assign w_grant_a   = bus.req_a_valid && (!bus.req_b_valid || r_last_b);
  assign w_grant_b   = bus.req_b_valid && !w_grant_a;
  assign w_push      = w_can_push && (bus.req_a_valid || bus.req_b_valid);
  assign w_push_name = w_grant_a ? bus.req_a_name : bus.req_b_name;

  assign bus.req_a_ready = w_push && w_grant_a;
  assign bus.req_b_ready = w_push && w_grant_b;

  assign w_pop       = (r_state == S_LOAD) && !bus.flush;
  assign w_last_pass = (r_state == S_SHOW) && bus.word_done && (r_rep == LAST_REP);

  // NOTE: every signal assigned in always_comb gets a default first so no
  // path leaves it unassigned and infers a latch.
  always_comb begin
    w_level_next = r_level;
    case ({w_push, w_pop})
      2'b10:   w_level_next = r_level + LVL_W'(1);
      2'b01:   w_level_next = r_level - LVL_W'(1);
      default: w_level_next = r_level;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_name   <= DEFAULT_NAME;
      r_rep    <= 4'd0;
      r_level  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_last_b <= 1'b1;
    end else if (bus.flush) begin
      // Flush beats word_done and any pop; the arbiter history is kept.
      r_state  <= S_IDLE;
      r_name   <= DEFAULT_NAME;
      r_rep    <= 4'd0;
      r_level  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      r_level <= w_level_next;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        r_last_b <= w_grant_b;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end

      case (r_state)
        S_IDLE: begin
          if (r_level != '0) begin
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_name  <= r_mem[r_rd_ptr];
          r_rep   <= 4'd0;
          r_state <= S_SHOW;
        end
        S_SHOW: begin
          if (w_last_pass) begin
            // Look at the level after this cycle's push so a name arriving
            // on the final pass is picked up without an idle detour.
            if (w_level_next != '0) begin
              r_state <= S_LOAD;
            end else begin
              r_state <= S_IDLE;
              r_name  <= DEFAULT_NAME;
            end
          end else if (bus.word_done) begin
            r_rep <= r_rep + 4'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_name  <= DEFAULT_NAME;
        end
      endcase
    end
  end

  // NOTE: the storage array has no reset; entries are only ever read after
  // being written, and the pointers/level carry all the validity state.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_push_name;
    end
  end

  assign bus.name        = r_name;
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.queue_level = r_level;

endmodule

// File: tb/tb_name_scheduler.sv
// -----------------------------------------------------------------------------
// tb_name_scheduler
// Directed cycle-by-cycle vector table (single request, tie arbitration,
// full-with-pop, flush, ignored pulses, ordering) followed by a randomized
// run compared against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_name_scheduler;
  localparam int         DEPTH = 4;
  localparam int         REP   = 2;
  localparam logic [2:0] DEF   = 3'd0;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  name_scheduler_if #(.FIFO_DEPTH(DEPTH)) bus ();

  name_scheduler #(
    .FIFO_DEPTH  (DEPTH),
    .REPEAT      (4'(REP)),
    .DEFAULT_NAME(DEF)
  ) u_dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  typedef struct {
    bit         rst;
    bit         av;
    logic [2:0] an;
    bit         bv;
    logic [2:0] bn;
    bit         fl;
    bit         wd;
    bit         era;
    bit         erb;
    logic [2:0] ename;
    bit         ebusy;
    int         elvl;
  } vec_t;

  function automatic vec_t v(input bit rst, input bit av, input logic [2:0] an,
                             input bit bv, input logic [2:0] bn, input bit fl,
                             input bit wd, input bit era, input bit erb,
                             input logic [2:0] ename, input bit ebusy, input int elvl);
    vec_t r;
    r.rst = rst; r.av = av; r.an = an; r.bv = bv; r.bn = bn; r.fl = fl; r.wd = wd;
    r.era = era; r.erb = erb; r.ename = ename; r.ebusy = ebusy; r.elvl = elvl;
    return r;
  endfunction

  task automatic drive(input bit rst, input bit av, input logic [2:0] an,
                       input bit bv, input logic [2:0] bn, input bit fl, input bit wd);
    reset           = rst;
    bus.req_a_valid = av;
    bus.req_a_name  = an;
    bus.req_b_valid = bv;
    bus.req_b_name  = bn;
    bus.flush       = fl;
    bus.word_done   = wd;
  endtask

  // ---------------- reference model ----------------
  int         m_q[$];
  logic [2:0] m_name;
  bit         m_loading;
  bit         m_showing;
  int         m_left;
  bit         m_last_b;

  // Computes this cycle's expected readys from the pre-edge view, then moves
  // the model to its post-edge view.
  task automatic model_cycle(input bit rst, input bit av, input logic [2:0] an,
                             input bit bv, input logic [2:0] bn, input bit fl,
                             input bit wd, output bit era, output bit erb);
    bit push_ok;
    bit ga;
    bit gb;
    bit final_pass;
    int pre;
    push_ok = !rst && !fl && (m_q.size() < DEPTH) && (av || bv);
    ga      = push_ok && av && (!bv || m_last_b);
    gb      = push_ok && !ga;
    era     = ga;
    erb     = gb;
    if (rst) begin
      m_q.delete();
      m_name = DEF; m_loading = 0; m_showing = 0; m_left = 0; m_last_b = 1;
    end else if (fl) begin
      m_q.delete();
      m_name = DEF; m_loading = 0; m_showing = 0; m_left = 0;
    end else begin
      pre        = m_q.size();
      final_pass = 0;
      if (m_loading) begin
        m_name    = 3'(m_q.pop_front());
        m_loading = 0;
        m_showing = 1;
        m_left    = REP;
      end else if (m_showing) begin
        if (wd) begin
          m_left--;
          if (m_left == 0) final_pass = 1;
        end
      end else if (pre != 0) begin
        m_loading = 1;
      end
      if (ga) begin m_q.push_back(int'(an)); m_last_b = 0; end
      if (gb) begin m_q.push_back(int'(bn)); m_last_b = 1; end
      if (final_pass) begin
        m_showing = 0;
        if (m_q.size() != 0) m_loading = 1;
        else                 m_name = DEF;
      end
    end
  endtask

  vec_t vecs[$];

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0);

    // rst av an bv bn fl wd | era erb name busy lvl
    vecs.push_back(v(1,0,0,0,0,0,0, 0,0, 0,0,0));
    // single request from A, name 5
    vecs.push_back(v(0,1,5,0,0,0,0, 1,0, 0,0,1));
    vecs.push_back(v(0,0,0,0,0,0,0, 0,0, 0,1,1));
    vecs.push_back(v(0,0,0,0,0,0,0, 0,0, 5,1,0));
    vecs.push_back(v(0,0,0,0,0,0,1, 0,0, 5,1,0));
    vecs.push_back(v(0,0,0,0,0,0,1, 0,0, 0,0,0));
    // reset with both valid: readys stay low, last grant returns to B
    vecs.push_back(v(1,1,1,1,2,0,0, 0,0, 0,0,0));
    // tie arbitration A=1 / B=2
    vecs.push_back(v(0,1,1,1,2,0,0, 1,0, 0,0,1));
    vecs.push_back(v(0,1,1,1,2,0,0, 0,1, 0,1,2));
    vecs.push_back(v(0,1,1,1,2,0,0, 1,0, 1,1,2));
    vecs.push_back(v(0,1,1,1,2,0,0, 0,1, 1,1,3));
    vecs.push_back(v(0,1,1,1,2,0,0, 1,0, 1,1,4));
    vecs.push_back(v(0,1,1,1,2,0,0, 0,0, 1,1,4));
    vecs.push_back(v(0,1,1,1,2,0,0, 0,0, 1,1,4));
    // full with pop: A valid while the final pass completes
    vecs.push_back(v(0,1,1,0,0,0,1, 0,0, 1,1,4));
    vecs.push_back(v(0,1,1,0,0,0,1, 0,0, 1,1,4));
    vecs.push_back(v(0,1,1,0,0,0,0, 0,0, 2,1,3));
    vecs.push_back(v(0,1,1,0,0,0,0, 1,0, 2,1,4));
    vecs.push_back(v(0,0,0,0,0,0,0, 0,0, 2,1,4));
    // flush together with word_done and an A request
    vecs.push_back(v(0,1,3,0,0,1,1, 0,0, 0,0,0));
    vecs.push_back(v(0,0,0,0,0,0,0, 0,0, 0,0,0));
    // word_done ignored in IDLE and LOAD; exactly REPEAT passes in SHOW
    vecs.push_back(v(0,0,0,0,0,0,1, 0,0, 0,0,0));
    vecs.push_back(v(0,0,0,0,0,0,1, 0,0, 0,0,0));
    vecs.push_back(v(0,1,6,0,0,0,1, 1,0, 0,0,1));
    vecs.push_back(v(0,0,0,0,0,0,1, 0,0, 0,1,1));
    vecs.push_back(v(0,0,0,0,0,0,1, 0,0, 6,1,0));
    vecs.push_back(v(0,0,0,0,0,0,1, 0,0, 6,1,0));
    vecs.push_back(v(0,0,0,0,0,0,1, 0,0, 0,0,0));
    vecs.push_back(v(0,0,0,0,0,0,1, 0,0, 0,0,0));
    // ordering: B queues 3, 4, 6
    vecs.push_back(v(1,0,0,0,0,0,0, 0,0, 0,0,0));
    vecs.push_back(v(0,0,0,1,3,0,0, 0,1, 0,0,1));
    vecs.push_back(v(0,0,0,1,4,0,0, 0,1, 0,1,2));
    vecs.push_back(v(0,0,0,1,6,0,0, 0,1, 3,1,2));
    vecs.push_back(v(0,0,0,0,0,0,0, 0,0, 3,1,2));
    vecs.push_back(v(0,0,0,0,0,0,1, 0,0, 3,1,2));
    vecs.push_back(v(0,0,0,0,0,0,1, 0,0, 3,1,2));
    vecs.push_back(v(0,0,0,0,0,0,0, 0,0, 4,1,1));
    vecs.push_back(v(0,0,0,0,0,0,1, 0,0, 4,1,1));
    vecs.push_back(v(0,0,0,0,0,0,1, 0,0, 4,1,1));
    vecs.push_back(v(0,0,0,0,0,0,0, 0,0, 6,1,0));
    vecs.push_back(v(0,0,0,0,0,0,1, 0,0, 6,1,0));
    vecs.push_back(v(0,0,0,0,0,0,1, 0,0, 0,0,0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].av, vecs[i].an, vecs[i].bv, vecs[i].bn,
            vecs[i].fl, vecs[i].wd);
      @(negedge clk);
      check($sformatf("vec%0d req_a_ready", i), 32'(bus.req_a_ready), 32'(vecs[i].era));
      check($sformatf("vec%0d req_b_ready", i), 32'(bus.req_b_ready), 32'(vecs[i].erb));
      @(posedge clk);
      #1;
      check($sformatf("vec%0d name", i),        32'(bus.name),        32'(vecs[i].ename));
      check($sformatf("vec%0d busy", i),        32'(bus.busy),        32'(vecs[i].ebusy));
      check($sformatf("vec%0d queue_level", i), 32'(bus.queue_level), 32'(vecs[i].elvl));
    end

    // Randomized run against the reference model; first cycle is a reset.
    for (int c = 0; c < 3000; c++) begin
      bit         rst, av, bv, fl, wd, era, erb;
      logic [2:0] an, bn;
      rst = (c == 0) || ($urandom_range(0, 199) == 0);
      av  = $urandom_range(0, 1);
      bv  = $urandom_range(0, 2) == 0;
      an  = 3'($urandom_range(0, 7));
      bn  = 3'($urandom_range(0, 7));
      fl  = $urandom_range(0, 59) == 0;
      wd  = $urandom_range(0, 3) == 0;
      drive(rst, av, an, bv, bn, fl, wd);
      model_cycle(rst, av, an, bv, bn, fl, wd, era, erb);
      @(negedge clk);
      check($sformatf("rnd%0d req_a_ready", c), 32'(bus.req_a_ready), 32'(era));
      check($sformatf("rnd%0d req_b_ready", c), 32'(bus.req_b_ready), 32'(erb));
      @(posedge clk);
      #1;
      check($sformatf("rnd%0d name", c),        32'(bus.name),        32'(m_name));
      check($sformatf("rnd%0d busy", c),        32'(bus.busy),        32'(m_loading || m_showing));
      check($sformatf("rnd%0d queue_level", c), 32'(bus.queue_level), 32'(m_q.size()));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
